// File: rtl/serial_tx_if.sv
// Load port of the serial transmitter: a valid/ready handshake carrying one word.
interface serial_tx_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] load_data;
    logic             load_valid;
    logic             load_ready;

    modport master (
        output load_data,
        output load_valid,
        input  load_ready
    );

    modport slave (
        input  load_data,
        input  load_valid,
        output load_ready
    );
endinterface

// File: rtl/serial_tx.sv
// Framed parallel-to-serial transmitter with a one-entry holding buffer.
// Bits launch on the rising edge so the downstream receiver can sample them
// mid-bit on the falling edge. An optional even-parity bit follows the data.
//
//   state | meaning
//   IDLE  | line quiet, waiting for a held word
//   SHIFT | frame on the line, cnt = index of the bit currently driven
//   GAP   | one quiet cycle after a frame, done pulses here
module serial_tx #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1,
    parameter int PARITY_EN = 0
) (
    input  logic        clock,
    input  logic        reset,
    serial_tx_if.slave  load,
    output logic        sdata,
    output logic        sframe,
    output logic        done
);

    localparam int N     = WIDTH + ((PARITY_EN != 0) ? 1 : 0);
    localparam int CNT_W = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N-1:0]     shift_q, shift_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic             sdata_d, sframe_d, done_d;
    logic             take;
    logic             accept;
    logic [N-1:0]     frame;

    // Frame in transmit order: frame[N-1] goes out first, parity (if any) last.
    function automatic logic [N-1:0] build_frame(input logic [WIDTH-1:0] d);
        logic [N-1:0] f;
        f = '0;
        for (int i = 0; i < WIDTH; i++) begin
            f[N-1-i] = (MSB_FIRST != 0) ? d[WIDTH-1-i] : d[i];
        end
        if (PARITY_EN != 0) begin
            f[0] = ^d;
        end
        return f;
    endfunction

    assign load.load_ready = !hold_full_q;
    assign accept          = load.load_valid && !hold_full_q;
    assign frame           = build_frame(hold_q);

    // Next-state, shifter and holding-buffer logic; outputs default to a quiet line.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        sdata_d     = 1'b0;
        sframe_d    = 1'b0;
        done_d      = 1'b0;
        take        = 1'b0;

        case (state_q)
            IDLE: begin
                if (hold_full_q) begin
                    take = 1'b1;
                end
            end
            SHIFT: begin
                if (cnt_q == CNT_W'(N - 1)) begin
                    state_d = GAP;
                    done_d  = 1'b1;
                end else begin
                    cnt_d    = cnt_q + 1'b1;
                    sdata_d  = shift_q[N-1];
                    shift_d  = shift_q << 1;
                    sframe_d = 1'b1;
                end
            end
            GAP: begin
                if (hold_full_q) begin
                    take = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Moving the held word into the shifter frees the buffer; take and
        // accept are exclusive because one needs the buffer full, the other empty.
        if (take) begin
            state_d     = SHIFT;
            cnt_d       = '0;
            sdata_d     = frame[N-1];
            shift_d     = frame << 1;
            sframe_d    = 1'b1;
            hold_full_d = 1'b0;
        end
        if (accept) begin
            hold_d      = load.load_data;
            hold_full_d = 1'b1;
        end
    end

    // State and registered line outputs; reset drops everything, including held data.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            sdata       <= 1'b0;
            sframe      <= 1'b0;
            done        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            sdata       <= sdata_d;
            sframe      <= sframe_d;
            done        <= done_d;
        end
    end

endmodule

// File: tb/tb_serial_tx.sv
// Bench for serial_tx: instance A is MSB-first with parity, instance B is
// LSB-first without parity. Expected bits are queued when a word is offered and
// popped by a falling-edge monitor for every framed bit.
module tb_serial_tx;

    logic clock;
    logic reset;
    logic sdata_a, sframe_a, done_a;
    logic sdata_b, sframe_b, done_b;

    int vectors;
    int miscompares;
    int bits_a, dones_a, bits_b, dones_b;
    bit exp_a[$];
    bit exp_b[$];
    bit eb_a, eb_b;

    serial_tx_if #(.WIDTH(8)) bus_a ();
    serial_tx_if #(.WIDTH(8)) bus_b ();

    serial_tx #(.WIDTH(8), .MSB_FIRST(1), .PARITY_EN(1)) dut_a (
        .clock (clock),
        .reset (reset),
        .load  (bus_a),
        .sdata (sdata_a),
        .sframe(sframe_a),
        .done  (done_a)
    );

    serial_tx #(.WIDTH(8), .MSB_FIRST(0), .PARITY_EN(0)) dut_b (
        .clock (clock),
        .reset (reset),
        .load  (bus_b),
        .sdata (sdata_b),
        .sframe(sframe_b),
        .done  (done_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Stream monitor for A: pops one expected bit per framed cycle.
    always @(negedge clock) begin
        if (reset === 1'b1) begin
            vectors++;
            if (sframe_a === 1'b1) begin
                bits_a++;
                if (exp_a.size() == 0) begin
                    miscompares++;
                    $display("FAIL stream_a: extra framed bit %b, none expected", sdata_a);
                end else begin
                    eb_a = exp_a.pop_front();
                    if (sdata_a !== eb_a) begin
                        miscompares++;
                        $display("FAIL stream_a bit %0d: got %b want %b", bits_a, sdata_a, eb_a);
                    end
                end
            end else if (sdata_a !== 1'b0) begin
                miscompares++;
                $display("FAIL idle_sdata_a: got %b want 0", sdata_a);
            end
            if (done_a === 1'b1) begin
                dones_a++;
            end
        end
    end

    // Stream monitor for B.
    always @(negedge clock) begin
        if (reset === 1'b1) begin
            vectors++;
            if (sframe_b === 1'b1) begin
                bits_b++;
                if (exp_b.size() == 0) begin
                    miscompares++;
                    $display("FAIL stream_b: extra framed bit %b, none expected", sdata_b);
                end else begin
                    eb_b = exp_b.pop_front();
                    if (sdata_b !== eb_b) begin
                        miscompares++;
                        $display("FAIL stream_b bit %0d: got %b want %b", bits_b, sdata_b, eb_b);
                    end
                end
            end else if (sdata_b !== 1'b0) begin
                miscompares++;
                $display("FAIL idle_sdata_b: got %b want 0", sdata_b);
            end
            if (done_b === 1'b1) begin
                dones_b++;
            end
        end
    end

    task automatic push_a(input logic [7:0] d);
        for (int i = 7; i >= 0; i--) exp_a.push_back(d[i]);
        exp_a.push_back(^d);
    endtask

    task automatic push_b(input logic [7:0] d);
        for (int i = 0; i < 8; i++) exp_b.push_back(d[i]);
    endtask

    task automatic send_a(input logic [7:0] d);
        int n;
        n = 0;
        @(negedge clock);
        while (bus_a.load_ready !== 1'b1 && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (n >= 100) begin
            miscompares++;
            $display("FAIL send_a timeout: load_ready stayed %b, want 1", bus_a.load_ready);
        end
        bus_a.load_data  = d;
        bus_a.load_valid = 1'b1;
        push_a(d);
        @(posedge clock);
        #1;
        bus_a.load_valid = 1'b0;
    endtask

    task automatic send_b(input logic [7:0] d);
        int n;
        n = 0;
        @(negedge clock);
        while (bus_b.load_ready !== 1'b1 && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (n >= 100) begin
            miscompares++;
            $display("FAIL send_b timeout: load_ready stayed %b, want 1", bus_b.load_ready);
        end
        bus_b.load_data  = d;
        bus_b.load_valid = 1'b1;
        push_b(d);
        @(posedge clock);
        #1;
        bus_b.load_valid = 1'b0;
    endtask

    task automatic wait_dones_a(input int target);
        int n;
        n = 0;
        while (dones_a < target && n < 80) begin
            @(negedge clock);
            #1;
            n++;
        end
        if (n >= 80) begin
            miscompares++;
            $display("FAIL wait_done_a timeout: got %0d pulses want %0d", dones_a, target);
        end
        repeat (3) @(negedge clock);
        #1;
    endtask

    task automatic test_reset();
        #2;
        vectors += 5;
        if (sdata_a !== 1'b0) begin miscompares++; $display("FAIL reset_sdata: got %b want 0", sdata_a); end
        if (sframe_a !== 1'b0) begin miscompares++; $display("FAIL reset_sframe: got %b want 0", sframe_a); end
        if (done_a !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", done_a); end
        if (bus_a.load_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready_a: got %b want 1", bus_a.load_ready); end
        if (bus_b.load_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready_b: got %b want 1", bus_b.load_ready); end
        // Offered data while in reset must be ignored.
        bus_a.load_valid = 1'b1;
        repeat (3) @(negedge clock);
        bus_a.load_valid = 1'b0;
        reset = 1'b1;
        repeat (4) @(negedge clock);
        #1;
        vectors++;
        if (sframe_a !== 1'b0 || bits_a != 0) begin
            miscompares++;
            $display("FAIL reset_ignore_load: sframe %b bits %0d, want 0/0", sframe_a, bits_a);
        end
    endtask

    task automatic test_a5_parity();
        bits_a = 0; dones_a = 0;
        send_a(8'hA5);
        @(negedge clock);
        vectors += 2;
        if (sframe_a !== 1'b0) begin miscompares++; $display("FAIL latency_early: sframe %b want 0", sframe_a); end
        if (bus_a.load_ready !== 1'b0) begin miscompares++; $display("FAIL ready_full: got %b want 0", bus_a.load_ready); end
        @(negedge clock);
        vectors += 2;
        if (sframe_a !== 1'b1) begin miscompares++; $display("FAIL latency_first: sframe %b want 1", sframe_a); end
        if (bus_a.load_ready !== 1'b1) begin miscompares++; $display("FAIL ready_free: got %b want 1", bus_a.load_ready); end
        wait_dones_a(1);
        vectors += 3;
        if (dones_a != 1) begin miscompares++; $display("FAIL a5_done: got %0d want 1", dones_a); end
        if (bits_a != 9) begin miscompares++; $display("FAIL a5_len: got %0d want 9", bits_a); end
        if (exp_a.size() != 0) begin miscompares++; $display("FAIL a5_left: got %0d want 0", exp_a.size()); end
    endtask

    task automatic test_07_parity();
        bits_a = 0; dones_a = 0;
        send_a(8'h07);
        wait_dones_a(1);
        vectors += 3;
        if (dones_a != 1) begin miscompares++; $display("FAIL x07_done: got %0d want 1", dones_a); end
        if (bits_a != 9) begin miscompares++; $display("FAIL x07_len: got %0d want 9", bits_a); end
        if (exp_a.size() != 0) begin miscompares++; $display("FAIL x07_left: got %0d want 0", exp_a.size()); end
    endtask

    task automatic test_lsb_noparity();
        int n;
        bits_b = 0; dones_b = 0;
        send_b(8'h01);
        n = 0;
        while (dones_b < 1 && n < 80) begin
            @(negedge clock);
            #1;
            n++;
        end
        repeat (3) @(negedge clock);
        #1;
        vectors += 3;
        if (dones_b != 1) begin miscompares++; $display("FAIL lsb_done: got %0d want 1", dones_b); end
        if (bits_b != 8) begin miscompares++; $display("FAIL lsb_len: got %0d want 8", bits_b); end
        if (exp_b.size() != 0) begin miscompares++; $display("FAIL lsb_left: got %0d want 0", exp_b.size()); end
    endtask

    task automatic test_back_to_back();
        int n;
        bits_a = 0; dones_a = 0;
        send_a(8'hA5);
        send_a(8'h3C);
        @(negedge clock);
        vectors += 2;
        if (bus_a.load_ready !== 1'b0) begin miscompares++; $display("FAIL b2b_wait_ready: got %b want 0", bus_a.load_ready); end
        if (sframe_a !== 1'b1) begin miscompares++; $display("FAIL b2b_overlap: sframe %b want 1", sframe_a); end
        n = 0;
        while (done_a !== 1'b1 && n < 40) begin
            @(negedge clock);
            n++;
        end
        vectors += 2;
        if (n >= 40) begin miscompares++; $display("FAIL b2b_first_done timeout: done %b want 1", done_a); end
        if (sframe_a !== 1'b0) begin miscompares++; $display("FAIL b2b_gap: sframe %b want 0", sframe_a); end
        @(negedge clock);
        vectors++;
        if (sframe_a !== 1'b1) begin miscompares++; $display("FAIL b2b_gap_len: sframe %b want 1", sframe_a); end
        wait_dones_a(2);
        vectors += 3;
        if (dones_a != 2) begin miscompares++; $display("FAIL b2b_done: got %0d want 2", dones_a); end
        if (bits_a != 18) begin miscompares++; $display("FAIL b2b_len: got %0d want 18", bits_a); end
        if (exp_a.size() != 0) begin miscompares++; $display("FAIL b2b_left: got %0d want 0", exp_a.size()); end
    endtask

    task automatic test_hold_stable();
        int n;
        int accepts;
        logic [7:0] d;
        bits_a = 0; dones_a = 0;
        accepts = 0;
        n = 0;
        @(negedge clock);
        bus_a.load_valid = 1'b1;
        while (accepts < 3 && n < 100) begin
            d = 8'($urandom);
            bus_a.load_data = d;
            if (bus_a.load_ready === 1'b1) begin
                push_a(d);
                accepts++;
            end
            @(negedge clock);
            n++;
        end
        bus_a.load_valid = 1'b0;
        wait_dones_a(3);
        vectors += 3;
        if (dones_a != 3) begin miscompares++; $display("FAIL hold_done: got %0d want 3", dones_a); end
        if (bits_a != 27) begin miscompares++; $display("FAIL hold_len: got %0d want 27", bits_a); end
        if (exp_a.size() != 0) begin miscompares++; $display("FAIL hold_left: got %0d want 0", exp_a.size()); end
    endtask

    task automatic test_reset_midframe();
        int n;
        bits_a = 0; dones_a = 0;
        send_a(8'hA5);
        send_a(8'h77);
        n = 0;
        while (bits_a < 3 && n < 40) begin
            @(negedge clock);
            #1;
            n++;
        end
        #2;
        reset = 1'b0;
        #1;
        vectors += 5;
        if (n >= 40) begin miscompares++; $display("FAIL rst_mid timeout: bits %0d want 3", bits_a); end
        if (sdata_a !== 1'b0) begin miscompares++; $display("FAIL rst_mid_sdata: got %b want 0", sdata_a); end
        if (sframe_a !== 1'b0) begin miscompares++; $display("FAIL rst_mid_sframe: got %b want 0", sframe_a); end
        if (done_a !== 1'b0) begin miscompares++; $display("FAIL rst_mid_done: got %b want 0", done_a); end
        if (bus_a.load_ready !== 1'b1) begin miscompares++; $display("FAIL rst_mid_ready: got %b want 1", bus_a.load_ready); end
        exp_a.delete();
        repeat (2) @(negedge clock);
        reset = 1'b1;
        repeat (12) @(negedge clock);
        #1;
        vectors += 2;
        if (dones_a != 0) begin miscompares++; $display("FAIL rst_mid_nodone: got %0d want 0", dones_a); end
        if (bits_a != 3) begin miscompares++; $display("FAIL rst_mid_held_dropped: bits %0d want 3", bits_a); end
        send_a(8'h3C);
        wait_dones_a(1);
        vectors += 3;
        if (dones_a != 1) begin miscompares++; $display("FAIL rst_after_done: got %0d want 1", dones_a); end
        if (bits_a != 12) begin miscompares++; $display("FAIL rst_after_len: got %0d want 12", bits_a); end
        if (exp_a.size() != 0) begin miscompares++; $display("FAIL rst_after_left: got %0d want 0", exp_a.size()); end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        bits_a = 0; dones_a = 0; bits_b = 0; dones_b = 0;
        reset = 1'b0;
        bus_a.load_valid = 1'b0;
        bus_a.load_data  = 8'h00;
        bus_b.load_valid = 1'b0;
        bus_b.load_data  = 8'h00;

        test_reset();
        test_a5_parity();
        test_07_parity();
        test_lsb_noparity();
        test_back_to_back();
        test_hold_stable();
        test_reset_midframe();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
